// File: rtl/tx_rx_switch_ctrl.sv
// -----------------------------------------------------------------------------
// tx_rx_switch_ctrl
//
// Sequences the RF front-end around a transmit burst. On entry the T/R switch
// moves to TX and is given time to settle before the PA is enabled. On exit
// the PA is dropped first, and the switch returns to RX only after a second
// settle period. RX processing stays blanked until a recovery tail has
// elapsed. A microsecond-resolution watchdog limits PA-on time, and a
// free-running counter tallies completed baseband frames.
//
// Ports
//   clk                  in   xpu clock
//   rstn                 in   asynchronous active-low reset
//   tx_chain_on          in   TX chain request (level)
//   tx_rf_is_ongoing     in   RF-level TX activity (level), forces rx_blank
//   pulse_tx_bb_end      in   one-cycle end-of-baseband pulse
//   tsf_pulse_1M         in   one-cycle 1 us tick
//   sw_settle_count_top  in   [7:0]  switch settle time, clk cycles
//   rx_recover_count_top in   [7:0]  RX blanking tail, clk cycles
//   tx_watchdog_top      in   [11:0] max PA-on time in us, 0 disables
//   trx_switch           out  1 = antenna to TX path
//   pa_en                out  PA enable
//   rx_blank             out  suppress RX processing
//   tx_watchdog_err      out  sticky watchdog fault
//   tx_frame_count       out  [15:0] completed baseband frames, wraps
//   fsm_state            out  [2:0]  current state, for debug
// -----------------------------------------------------------------------------
module tx_rx_switch_ctrl (
   input  logic        clk,
   input  logic        rstn,
   input  logic        tx_chain_on,
   input  logic        tx_rf_is_ongoing,
   input  logic        pulse_tx_bb_end,
   input  logic        tsf_pulse_1M,
   input  logic [7:0]  sw_settle_count_top,
   input  logic [7:0]  rx_recover_count_top,
   input  logic [11:0] tx_watchdog_top,
   output logic        trx_switch,
   output logic        pa_en,
   output logic        rx_blank,
   output logic        tx_watchdog_err,
   output logic [15:0] tx_frame_count,
   output logic [2:0]  fsm_state
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SW_TX   = 3'd1,
      ST_TX      = 3'd2,
      ST_SW_RX   = 3'd3,
      ST_RECOVER = 3'd4
   } state_t;

   state_t      state_reg, state_next;
   logic [7:0]  cnt_reg, cnt_next;
   logic [11:0] wd_reg, wd_next;
   logic        trx_switch_reg, trx_switch_next;
   logic        pa_en_reg, pa_en_next;
   logic        rx_blank_reg, rx_blank_next;
   logic        wd_err_reg, wd_err_next;
   logic [15:0] frame_cnt_reg, frame_cnt_next;
   logic        rearm;

   // A new burst may start only when requested and no watchdog fault is pending.
   assign rearm = tx_chain_on & ~wd_err_reg;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_reg      <= ST_IDLE;
         cnt_reg        <= 8'd0;
         wd_reg         <= 12'd0;
         trx_switch_reg <= 1'b0;
         pa_en_reg      <= 1'b0;
         rx_blank_reg   <= 1'b0;
         wd_err_reg     <= 1'b0;
         frame_cnt_reg  <= 16'd0;
      end else begin
         state_reg      <= state_next;
         cnt_reg        <= cnt_next;
         wd_reg         <= wd_next;
         trx_switch_reg <= trx_switch_next;
         pa_en_reg      <= pa_en_next;
         rx_blank_reg   <= rx_blank_next;
         wd_err_reg     <= wd_err_next;
         frame_cnt_reg  <= frame_cnt_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      trx_switch_next = trx_switch_reg;
      pa_en_next      = 1'b0;
      // The fault is cleared by any cycle with the request low.
      wd_err_next     = wd_err_reg & tx_chain_on;

      case (state_reg)
         ST_IDLE: begin
            trx_switch_next = 1'b0;
            if (rearm) begin
               state_next      = ST_SW_TX;
               trx_switch_next = 1'b1;
            end
         end
         ST_SW_TX: begin
            trx_switch_next = 1'b1;
            if (!tx_chain_on) begin
               state_next = ST_SW_RX;
            end else if (cnt_reg == sw_settle_count_top) begin
               state_next = ST_TX;
               pa_en_next = 1'b1;
            end
         end
         ST_TX: begin
            trx_switch_next = 1'b1;
            pa_en_next      = 1'b1;
            // A dropped request wins over a simultaneous expiry: no fault.
            if (!tx_chain_on) begin
               state_next = ST_SW_RX;
               pa_en_next = 1'b0;
            end else if ((tx_watchdog_top != 12'd0) && (wd_reg == tx_watchdog_top)) begin
               state_next  = ST_SW_RX;
               pa_en_next  = 1'b0;
               wd_err_next = 1'b1;
            end
         end
         ST_SW_RX: begin
            trx_switch_next = 1'b1;
            if (rearm) begin
               state_next = ST_SW_TX;
            end else if (cnt_reg == sw_settle_count_top) begin
               state_next      = ST_RECOVER;
               trx_switch_next = 1'b0;
            end
         end
         ST_RECOVER: begin
            trx_switch_next = 1'b0;
            if (rearm) begin
               state_next      = ST_SW_TX;
               trx_switch_next = 1'b1;
            end else if (cnt_reg == rx_recover_count_top) begin
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next      = ST_IDLE;
            trx_switch_next = 1'b0;
         end
      endcase

      // Dwell counter restarts on every state change, including SW_RX -> SW_TX.
      if (state_next != state_reg) begin
         cnt_next = 8'd0;
      end else if ((state_reg == ST_SW_TX) || (state_reg == ST_SW_RX) ||
                   (state_reg == ST_RECOVER)) begin
         cnt_next = cnt_reg + 8'd1;
      end else begin
         cnt_next = cnt_reg;
      end

      // Held at zero outside TX, so it is already clear on TX entry.
      if (state_reg != ST_TX) begin
         wd_next = 12'd0;
      end else if (tsf_pulse_1M) begin
         wd_next = wd_reg + 12'd1;
      end else begin
         wd_next = wd_reg;
      end

      rx_blank_next  = (state_next != ST_IDLE) | tx_rf_is_ongoing;
      frame_cnt_next = frame_cnt_reg + {15'd0, pulse_tx_bb_end};
   end

   assign trx_switch      = trx_switch_reg;
   assign pa_en           = pa_en_reg;
   assign rx_blank        = rx_blank_reg;
   assign tx_watchdog_err = wd_err_reg;
   assign tx_frame_count  = frame_cnt_reg;
   assign fsm_state       = state_reg;

endmodule

// File: tb/tb_tx_rx_switch_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for tx_rx_switch_ctrl. A phase/dwell-countdown model derived from the
// sequencing rules predicts every output after each clock edge; directed
// scenarios plus randomized segments drive the DUT.
// -----------------------------------------------------------------------------
module tb_tx_rx_switch_ctrl;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        tx_chain_on = 1'b0;
   logic        tx_rf_is_ongoing = 1'b0;
   logic        pulse_tx_bb_end = 1'b0;
   logic        tsf_pulse_1M = 1'b0;
   logic [7:0]  sw_settle_count_top = 8'd4;
   logic [7:0]  rx_recover_count_top = 8'd10;
   logic [11:0] tx_watchdog_top = 12'd0;
   logic        trx_switch, pa_en, rx_blank, tx_watchdog_err;
   logic [15:0] tx_frame_count;
   logic [2:0]  fsm_state;

   tx_rx_switch_ctrl dut (
      .clk                  (clk),
      .rstn                 (rstn),
      .tx_chain_on          (tx_chain_on),
      .tx_rf_is_ongoing     (tx_rf_is_ongoing),
      .pulse_tx_bb_end      (pulse_tx_bb_end),
      .tsf_pulse_1M         (tsf_pulse_1M),
      .sw_settle_count_top  (sw_settle_count_top),
      .rx_recover_count_top (rx_recover_count_top),
      .tx_watchdog_top      (tx_watchdog_top),
      .trx_switch           (trx_switch),
      .pa_en                (pa_en),
      .rx_blank             (rx_blank),
      .tx_watchdog_err      (tx_watchdog_err),
      .tx_frame_count       (tx_frame_count),
      .fsm_state            (fsm_state)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Phase numbers are the externally visible fsm_state values.
   localparam int P_IDLE = 0, P_SW_TX = 1, P_TX = 2, P_SW_RX = 3, P_REC = 4;
   int m_phase, m_left, m_wd, m_frames;
   bit m_err, m_rxb;

   task automatic m_reset();
      m_phase = P_IDLE; m_left = 0; m_wd = 0; m_frames = 0; m_err = 0; m_rxb = 0;
   endtask

   // m_left = edges still to be spent in the phase before its exit condition fires.
   task automatic m_enter(input int p);
      m_phase = p;
      m_wd    = 0;
      if (p == P_SW_TX || p == P_SW_RX) m_left = int'(sw_settle_count_top);
      else if (p == P_REC)              m_left = int'(rx_recover_count_top);
      else                              m_left = 0;
   endtask

   task automatic m_step();
      bit go, new_err;
      if (!rstn) begin
         m_reset();
         return;
      end
      go      = tx_chain_on && !m_err;
      new_err = m_err && tx_chain_on;
      case (m_phase)
         P_IDLE:  if (go) m_enter(P_SW_TX);
         P_SW_TX: begin
            if (!tx_chain_on)     m_enter(P_SW_RX);
            else if (m_left == 0) m_enter(P_TX);
            else                  m_left--;
         end
         P_TX: begin
            if (!tx_chain_on) m_enter(P_SW_RX);
            else if (tx_watchdog_top != 0 && m_wd == int'(tx_watchdog_top)) begin
               new_err = 1;
               m_enter(P_SW_RX);
            end else if (tsf_pulse_1M) m_wd = (m_wd + 1) & 12'hFFF;
         end
         P_SW_RX: begin
            if (go)               m_enter(P_SW_TX);
            else if (m_left == 0) m_enter(P_REC);
            else                  m_left--;
         end
         default: begin
            if (go)               m_enter(P_SW_TX);
            else if (m_left == 0) m_enter(P_IDLE);
            else                  m_left--;
         end
      endcase
      m_err    = new_err;
      m_rxb    = (m_phase != P_IDLE) || tx_rf_is_ongoing;
      m_frames = (m_frames + int'(pulse_tx_bb_end)) & 16'hFFFF;
   endtask

   // ---------------- observation ----------------
   int cyc = 0;
   int t_trx_rise, t_trx_fall, t_pa_rise, t_pa_fall, t_rxb_fall;
   int trx_rise_cnt = 0, pa_rise_cnt = 0, rxb_fall_cnt = 0;
   logic prev_trx = 0, prev_pa = 0, prev_rxb = 0;
   logic [2:0] prev_state = 0;
   int state_seq[$];

   task automatic compare_all();
      check("fsm_state", fsm_state, m_phase);
      check("trx_switch", trx_switch, (m_phase == P_SW_TX || m_phase == P_TX || m_phase == P_SW_RX));
      check("pa_en", pa_en, m_phase == P_TX);
      check("rx_blank", rx_blank, m_rxb);
      check("wd_err", tx_watchdog_err, m_err);
      check("frames", tx_frame_count, m_frames);
      check("pa_implies_trx", pa_en & ~trx_switch, 0);
      if (trx_switch && !prev_trx) begin t_trx_rise = cyc; trx_rise_cnt++; end
      if (!trx_switch && prev_trx) t_trx_fall = cyc;
      if (pa_en && !prev_pa) begin t_pa_rise = cyc; pa_rise_cnt++; end
      if (!pa_en && prev_pa) t_pa_fall = cyc;
      if (!rx_blank && prev_rxb) begin t_rxb_fall = cyc; rxb_fall_cnt++; end
      if (fsm_state != prev_state) state_seq.push_back(int'(fsm_state));
      prev_trx = trx_switch; prev_pa = pa_en; prev_rxb = rx_blank; prev_state = fsm_state;
   endtask

   task automatic tick();
      @(posedge clk);
      m_step();
      #1;
      cyc++;
      compare_all();
   endtask

   task automatic wait_phase(input string tag, input int p, input int budget);
      int b = budget;
      while (fsm_state != 3'(p) && b > 0) begin
         tick();
         b--;
      end
      check(tag, fsm_state, p);
   endtask

   initial begin
      int t0, rises0, rxbf0, budget;
      int exp_seq[4];
      exp_seq = '{1, 3, 4, 0};
      m_reset();

      // ---- reset state ----
      repeat (3) tick();
      @(negedge clk) rstn = 1'b1;
      repeat (2) tick();

      // ---- basic burst ----
      sw_settle_count_top = 8'd4; rx_recover_count_top = 8'd10; tx_watchdog_top = 12'd0;
      t0 = cyc;
      tx_chain_on = 1'b1;
      repeat (100) tick();
      check("burst_trx_on", t_trx_rise - t0, 1);
      check("burst_pa_on", t_pa_rise - t_trx_rise, 5);
      t0 = cyc;
      tx_chain_on = 1'b0;
      repeat (40) tick();
      check("burst_pa_off", t_pa_fall - t0, 1);
      check("burst_trx_off", t_trx_fall - t_pa_fall, 5);
      check("burst_rxb_off", t_rxb_fall - t_trx_fall, 11);
      check("burst_idle", fsm_state, 0);

      // ---- abort in SW_TX ----
      sw_settle_count_top = 8'd8;
      state_seq.delete();
      rises0 = pa_rise_cnt;
      tx_chain_on = 1'b1;
      repeat (2) tick();
      tx_chain_on = 1'b0;
      repeat (30) tick();
      check("abort_no_pa", pa_rise_cnt - rises0, 0);
      check("abort_seq_len", state_seq.size(), 4);
      for (int i = 0; i < 4; i++) check("abort_seq", (i < state_seq.size()) ? state_seq[i] : -1, exp_seq[i]);

      // ---- watchdog ----
      sw_settle_count_top = 8'd4; rx_recover_count_top = 8'd10; tx_watchdog_top = 12'd3;
      rises0 = trx_rise_cnt;
      tx_chain_on = 1'b1;
      for (int i = 0; i < 500; i++) begin
         tsf_pulse_1M = (i % 100 == 99);
         tick();
      end
      tsf_pulse_1M = 1'b0;
      check("wd_err_set", tx_watchdog_err, 1);
      check("wd_held_idle", fsm_state, 0);
      check("wd_single_entry", trx_rise_cnt - rises0, 1);
      check("wd_pa_on_len", t_pa_fall - t_pa_rise, 300 - 6 + 1);
      tx_chain_on = 1'b0;
      tick();
      check("wd_err_clear", tx_watchdog_err, 0);
      tx_chain_on = 1'b1;
      tick();
      check("wd_rearm", fsm_state, 1);
      tx_chain_on = 1'b0;
      wait_phase("wd_back_idle", 0, 60);

      // ---- re-arm during RECOVER ----
      sw_settle_count_top = 8'd2; rx_recover_count_top = 8'd10; tx_watchdog_top = 12'd0;
      tx_chain_on = 1'b1;
      repeat (20) tick();
      tx_chain_on = 1'b0;
      rxbf0 = rxb_fall_cnt;
      wait_phase("rearm_reach_rec", 4, 60);
      repeat (3) tick();
      tx_chain_on = 1'b1;
      tick();
      check("rearm_trx", trx_switch, 1);
      check("rearm_state", fsm_state, 1);
      t0 = cyc;
      repeat (10) tick();
      check("rearm_pa_lat", t_pa_rise - t0, 3);
      check("rearm_rxb_held", rxb_fall_cnt - rxbf0, 0);
      tx_chain_on = 1'b0;
      wait_phase("rearm_idle", 0, 60);

      // ---- asynchronous reset mid-TX ----
      sw_settle_count_top = 8'd4;
      tx_chain_on = 1'b1;
      repeat (20) tick();
      check("rst_pre_pa", pa_en, 1);
      #2 rstn = 1'b0;
      #1;
      m_reset();
      check("rst_pa", pa_en, 0);
      check("rst_trx", trx_switch, 0);
      check("rst_rxb", rx_blank, 0);
      check("rst_state", fsm_state, 0);
      check("rst_frames", tx_frame_count, 0);
      tx_chain_on = 1'b0;
      repeat (2) tick();
      @(negedge clk) rstn = 1'b1;
      repeat (2) tick();
      check("rst_release_state", fsm_state, 0);

      // ---- frame counter wrap ----
      pulse_tx_bb_end = 1'b1;
      repeat (65535) tick();
      check("frames_full", tx_frame_count, 16'hFFFF);
      tick();
      pulse_tx_bb_end = 1'b0;
      check("frames_wrap", tx_frame_count, 16'h0000);

      // ---- randomized segments ----
      for (int seg = 0; seg < 8; seg++) begin
         tx_chain_on = 1'b0; tx_rf_is_ongoing = 1'b0; pulse_tx_bb_end = 1'b0; tsf_pulse_1M = 1'b0;
         budget = 600;
         while (m_phase != P_IDLE && budget > 0) begin tick(); budget--; end
         check("rand_idle", fsm_state, 0);
         // Thresholds change only while parked in IDLE with no request.
         sw_settle_count_top  = 8'($urandom_range(0, 5));
         rx_recover_count_top = 8'($urandom_range(0, 5));
         tx_watchdog_top      = 12'($urandom_range(0, 4));
         for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 19) == 0) tx_chain_on = ~tx_chain_on;
            tx_rf_is_ongoing = ($urandom_range(0, 7) == 0);
            pulse_tx_bb_end  = ($urandom_range(0, 3) == 0);
            tsf_pulse_1M     = ($urandom_range(0, 9) == 0);
            tick();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
